issue_hazard_ctrl: RTL
======================

ISSUE_HAZARD_CTRL -- requirements
Module: issue_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter MAX_LD_OUT, default 2, giving the maximum number of outstanding loads (range 1..3).
REQ-002 The block SHALL have parameter FLUSH_CYCLES, default 2, giving the number of bubble cycles after a redirect (range 1..4).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (asserted at 0).
REQ-005 valid_is_i  in  1  decoded instruction present in issue stage.
REQ-006 rs1_is_i, rs2_is_i, rd_is_i  in  5 each  source/destination register indices.
REQ-007 rs1_used_is_i, rs2_used_is_i  in  1 each  instruction reads rs1/rs2.
REQ-008 rf_en_is_i  in  1  instruction writes rd.
REQ-009 ld_is_i  in  1  instruction is a load.
REQ-010 ld_done_i  in  1  load data written back this cycle.
REQ-011 ld_rd_i  in  5  destination of the completing load.
REQ-012 redirect_i  in  1  branch/jump mispredict from execute.
REQ-013 stall_o  out  1  hold fetch/decode registers.
REQ-014 valid_ex_pipe_o  out  1  valid into issue-execute pipeline register.
REQ-015 clr_ex_o  out  1  clear of issue-execute pipeline register.
REQ-016 flush_is_o  out  1  kill fetch/decode contents.
REQ-017 sb_o  out  32  pending-write scoreboard, bit n = load to xn outstanding.
REQ-018 ld_cnt_o  out  2  outstanding load count.
REQ-019 state_o  out  2  FSM state: RUN=00, STALL=01, FLUSH=10.

Function
REQ-020 hazard SHALL be 1 when any of the following holds: a used rs (nonzero) has its sb bit set; rf_en_is_i with rd nonzero and sb[rd] set (WAW); ld_is_i with ld_cnt_o==MAX_LD_OUT.
REQ-021 A ld_done_i in the same cycle SHALL NOT clear a hazard; the clear takes effect the next cycle (no bypass).
REQ-022 issue = valid_is_i & ~hazard & ~redirect_i & state!=FLUSH; valid_ex_pipe_o = issue (combinational, zero latency).
REQ-023 stall_o = valid_is_i & hazard & state!=FLUSH & ~redirect_i.
REQ-024 clr_ex_o and flush_is_o SHALL be 1 in the redirect_i cycle and in every FLUSH cycle, else 0.
REQ-025 On issue of a load with rd nonzero, sb[rd] SHALL set and ld_cnt SHALL increment; a load to x0 SHALL NOT touch sb or ld_cnt.
REQ-026 ld_done_i with sb[ld_rd_i] set SHALL clear that bit and decrement ld_cnt; ld_done_i for a clear bit or for x0 SHALL be ignored.
REQ-027 Simultaneous issue-set and done-clear on the same register is impossible by construction (WAW stall); on different registers both SHALL apply, and ld_cnt SHALL be unchanged.
REQ-028 ld_cnt SHALL never exceed MAX_LD_OUT nor wrap below 0.
REQ-029 FSM transitions: RUN->STALL on stall_o; STALL->RUN on issue or ~valid_is_i; any state->FLUSH on redirect_i, loading counter with FLUSH_CYCLES-1; FLUSH decrements the counter and goes to RUN after the cycle in which the counter is 0.
REQ-030 redirect_i during FLUSH SHALL reload the counter; redirect_i SHALL NOT clear sb or ld_cnt, and ld_done_i SHALL be honoured in every state.

Reset
REQ-031 While reset==0, state SHALL be RUN, sb_o=0, ld_cnt_o=0, and the flush counter SHALL be 0; outputs SHALL follow their combinational equations from these values.
REQ-032 Assertion of reset mid-FLUSH or mid-STALL SHALL abandon the operation immediately; in-flight loads SHALL be forgotten.

Structure
REQ-033 The FSM state encodings and the MAX_LD_OUT/FLUSH_CYCLES defaults SHALL reside in the shared pipeline constants package.
REQ-034 The scoreboard plus counter SHALL be one sub-module, issue_scoreboard; the FSM and hazard logic SHALL be in the top module.

Verification
REQ-035 The bench SHALL cover the following directed scenarios:
- Load x5 issued, then add x6,x5,x1 -> stall_o=1 until the cycle after ld_done_i with ld_rd_i=5; then valid_ex_pipe_o=1.
- Three loads (x1,x2,x3) back-to-back, no done -> third stalls with ld_cnt_o=2; ld_done_i rd=1 -> third issues next cycle, sb_o=0x0000000C.
- redirect_i while stalled, FLUSH_CYCLES=2 -> clr_ex_o=flush_is_o=1 for 3 cycles (redirect + 2), state_o 10 then 00, sb_o unchanged.
- Load to x0 issued -> sb_o=0, ld_cnt_o=0; ld_done_i rd=7 with sb[7]=0 -> no change.
- reset=0 asynchronously mid-FLUSH with sb_o=0x20 -> immediately state_o=00, sb_o=0, ld_cnt_o=0, clr_ex_o=0.

Source files
------------

// File: rtl/issue_hazard_ctrl_pkg.sv
// Shared pipeline constants for the issue-stage hazard controller:
// FSM encodings, default parameters and register-file geometry.
package issue_hazard_ctrl_pkg;

  localparam int unsigned REG_AW           = 5;
  localparam int unsigned NUM_REGS         = 32;
  localparam int unsigned LD_CNT_W         = 2;
  localparam int unsigned FLUSH_CNT_W      = 2;
  localparam int unsigned DEF_MAX_LD_OUT   = 2;
  localparam int unsigned DEF_FLUSH_CYCLES = 2;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10
  } pipe_state_e;

  // One-hot mask selecting a single architectural register.
  function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_AW-1:0] idx);
    return NUM_REGS'(1) << idx;
  endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Pending-load scoreboard: one bit per destination register plus a count
// of outstanding loads. x0 is never tracked.
module issue_scoreboard
  import issue_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MAX_LD_OUT = DEF_MAX_LD_OUT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_set_en,
  input  logic [REG_AW-1:0]   i_set_rd,
  input  logic                i_clr_en,
  input  logic [REG_AW-1:0]   i_clr_rd,
  output logic [NUM_REGS-1:0] o_sb,
  output logic [LD_CNT_W-1:0] o_ld_cnt
);

  logic [NUM_REGS-1:0] r_sb;
  logic [LD_CNT_W-1:0] r_ld_cnt;
  logic                w_set;
  logic                w_clr;
  logic [NUM_REGS-1:0] w_sb_nxt;
  logic [LD_CNT_W-1:0] w_cnt_nxt;

  assign w_set = i_set_en && (i_set_rd != '0);
  // Completions for registers with no pending load are ignored.
  assign w_clr = i_clr_en && (i_clr_rd != '0) && r_sb[i_clr_rd];

  always_comb begin
    w_sb_nxt  = r_sb;
    w_cnt_nxt = r_ld_cnt;
    if (w_set) w_sb_nxt = w_sb_nxt | reg_mask(i_set_rd);
    if (w_clr) w_sb_nxt = w_sb_nxt & ~reg_mask(i_clr_rd);
    if (w_set && !w_clr && (r_ld_cnt < LD_CNT_W'(MAX_LD_OUT)))
      w_cnt_nxt = r_ld_cnt + LD_CNT_W'(1);
    else if (w_clr && !w_set && (r_ld_cnt != '0))
      w_cnt_nxt = r_ld_cnt - LD_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sb     <= '0;
      r_ld_cnt <= '0;
    end else begin
      r_sb     <= w_sb_nxt;
      r_ld_cnt <= w_cnt_nxt;
    end
  end

  assign o_sb     = r_sb;
  assign o_ld_cnt = r_ld_cnt;

endmodule

// File: rtl/issue_hazard_ctrl.sv
// Issue-stage hazard controller: RAW/WAW/load-capacity interlock against a
// pending-load scoreboard, plus redirect flush sequencing.
module issue_hazard_ctrl
  import issue_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MAX_LD_OUT   = DEF_MAX_LD_OUT,
  parameter int unsigned FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_is_i,
  input  logic [REG_AW-1:0]   rs1_is_i,
  input  logic [REG_AW-1:0]   rs2_is_i,
  input  logic [REG_AW-1:0]   rd_is_i,
  input  logic                rs1_used_is_i,
  input  logic                rs2_used_is_i,
  input  logic                rf_en_is_i,
  input  logic                ld_is_i,
  input  logic                ld_done_i,
  input  logic [REG_AW-1:0]   ld_rd_i,
  input  logic                redirect_i,
  output logic                stall_o,
  output logic                valid_ex_pipe_o,
  output logic                clr_ex_o,
  output logic                flush_is_o,
  output logic [NUM_REGS-1:0] sb_o,
  output logic [LD_CNT_W-1:0] ld_cnt_o,
  output logic [1:0]          state_o
);

  pipe_state_e            r_state;
  logic [FLUSH_CNT_W-1:0] r_fcnt;
  logic [NUM_REGS-1:0]    w_sb;
  logic [LD_CNT_W-1:0]    w_ld_cnt;
  logic                   w_hazard;
  logic                   w_in_flush;
  logic                   w_issue;
  logic                   w_stall;

  // Hazards see only the registered scoreboard, so a same-cycle completion
  // releases the interlock one cycle later.
  assign w_hazard = (rs1_used_is_i && (rs1_is_i != '0) && w_sb[rs1_is_i])
                 || (rs2_used_is_i && (rs2_is_i != '0) && w_sb[rs2_is_i])
                 || (rf_en_is_i && (rd_is_i != '0) && w_sb[rd_is_i])
                 || (ld_is_i && (w_ld_cnt == LD_CNT_W'(MAX_LD_OUT)));

  assign w_in_flush = (r_state == ST_FLUSH);
  assign w_issue    = valid_is_i && !w_hazard && !redirect_i && !w_in_flush;
  assign w_stall    = valid_is_i && w_hazard && !redirect_i && !w_in_flush;

  issue_scoreboard #(
    .MAX_LD_OUT (MAX_LD_OUT)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .i_set_en (w_issue && ld_is_i),
    .i_set_rd (rd_is_i),
    .i_clr_en (ld_done_i),
    .i_clr_rd (ld_rd_i),
    .o_sb     (w_sb),
    .o_ld_cnt (w_ld_cnt)
  );

  // Redirect wins from any state and (re)arms the bubble counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RUN;
      r_fcnt  <= '0;
    end else if (redirect_i) begin
      r_state <= ST_FLUSH;
      r_fcnt  <= FLUSH_CNT_W'(FLUSH_CYCLES - 1);
    end else begin
      case (r_state)
        ST_RUN:   if (w_stall) r_state <= ST_STALL;
        ST_STALL: if (w_issue || !valid_is_i) r_state <= ST_RUN;
        ST_FLUSH: begin
          if (r_fcnt == '0) r_state <= ST_RUN;
          else              r_fcnt  <= r_fcnt - FLUSH_CNT_W'(1);
        end
        default:  r_state <= ST_RUN;
      endcase
    end
  end

  assign stall_o         = w_stall;
  assign valid_ex_pipe_o = w_issue;
  assign clr_ex_o        = redirect_i || w_in_flush;
  assign flush_is_o      = redirect_i || w_in_flush;
  assign sb_o            = w_sb;
  assign ld_cnt_o        = w_ld_cnt;
  assign state_o         = r_state;

endmodule
